// File: rtl/wishbone_bram_dp.sv
// wishbone_bram_dp
//   Dual-initiator Wishbone B4 pipelined block RAM. Two ports (A, B) share one
//   single-port array through a combinational arbiter. Only one access is
//   granted per cycle, and the losing port sees STALL. Every byte lane can
//   optionally store a parity bit, which is checked on read. A failed check
//   terminates the read with ERR instead of ACK.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   X_CYC, X_STB      bus cycle / strobe (X = A or B)
//   X_WE              write enable
//   X_ADDR            word address (AddressBusWidth bits)
//   X_SEL             byte-lane select (Lanes bits)
//   X_DAT_I, X_DAT_O  write data / read data (8*Lanes bits)
//   X_ACK, X_ERR      single-cycle termination pulses
//   X_STALL           request not accepted this cycle (combinational)
//   ERR_INJ           inverts the stored parity of lanes written while high
module wishbone_bram_dp #(
  parameter int AddressBusWidth = 12,
  parameter int Lanes           = 4,
  parameter int Parity          = 1,
  parameter int ReadLatency     = 1,
  parameter int RoundRobin      = 1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       A_CYC,
  input  logic                       A_STB,
  input  logic                       A_WE,
  input  logic [AddressBusWidth-1:0] A_ADDR,
  input  logic [Lanes-1:0]           A_SEL,
  input  logic [8*Lanes-1:0]         A_DAT_I,
  output logic [8*Lanes-1:0]         A_DAT_O,
  output logic                       A_ACK,
  output logic                       A_ERR,
  output logic                       A_STALL,
  input  logic                       B_CYC,
  input  logic                       B_STB,
  input  logic                       B_WE,
  input  logic [AddressBusWidth-1:0] B_ADDR,
  input  logic [Lanes-1:0]           B_SEL,
  input  logic [8*Lanes-1:0]         B_DAT_I,
  output logic [8*Lanes-1:0]         B_DAT_O,
  output logic                       B_ACK,
  output logic                       B_ERR,
  output logic                       B_STALL,
  input  logic                       ERR_INJ
);

  localparam int DataWidth = 8 * Lanes;
  localparam int Depth     = 1 << AddressBusWidth;

  // ---------------------------------------------------------------- arbiter
  logic req_a, req_b, grant_a, grant_b;
  logic rr_b_first;  // B holds priority at the next contention

  assign req_a = A_CYC & A_STB;
  assign req_b = B_CYC & B_STB;

  always_comb begin
    grant_a = req_a & (~req_b | ~((RoundRobin != 0) & rr_b_first));
    grant_b = req_b & ~grant_a;
  end

  assign A_STALL = req_a & ~grant_a;
  assign B_STALL = req_b & ~grant_b;

  // The pointer only moves when both ports compete, so a lone requester
  // does not give up its turn at the next contention.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_b_first <= 1'b0;
    end else if (req_a & req_b) begin
      rr_b_first <= grant_a;
    end
  end

  // ------------------------------------------------------- granted request
  logic                       acc, g_port, g_we;
  logic [AddressBusWidth-1:0] g_addr;
  logic [Lanes-1:0]           g_sel;
  logic [DataWidth-1:0]       g_dat;

  always_comb begin
    acc    = grant_a | grant_b;
    g_port = grant_b;
    g_we   = grant_b ? B_WE    : A_WE;
    g_addr = grant_b ? B_ADDR  : A_ADDR;
    g_sel  = grant_b ? B_SEL   : A_SEL;
    g_dat  = grant_b ? B_DAT_I : A_DAT_I;
  end

  // ------------------------------------------------------------------ array
  // The array and its read register carry no reset, so the memory can map
  // onto block RAM. Contents survive RST_N.
  logic [DataWidth-1:0] mem [Depth];
  logic [DataWidth-1:0] rd_word;
  logic [Lanes-1:0]     rd_par_bad;

  always_ff @(posedge CLK) begin
    if (acc) begin
      if (g_we) begin
        for (int i = 0; i < Lanes; i++) begin
          if (g_sel[i]) mem[g_addr][8*i +: 8] <= g_dat[8*i +: 8];
        end
      end
      rd_word <= mem[g_addr];
    end
  end

  if (Parity != 0) begin : g_par
    logic [Lanes-1:0] par_mem [Depth];
    logic [Lanes-1:0] rd_par;

    always_ff @(posedge CLK) begin
      if (acc) begin
        if (g_we) begin
          for (int i = 0; i < Lanes; i++) begin
            if (g_sel[i]) par_mem[g_addr][i] <= (^g_dat[8*i +: 8]) ^ ERR_INJ;
          end
        end
        rd_par <= par_mem[g_addr];
      end
    end

    always_comb begin
      rd_par_bad = '0;
      for (int i = 0; i < Lanes; i++) begin
        rd_par_bad[i] = rd_par[i] ^ (^rd_word[8*i +: 8]);
      end
    end
  end else begin : g_nopar
    logic unused_err_inj;
    assign unused_err_inj = ERR_INJ;
    assign rd_par_bad     = '0;
  end

  // ------------------------------------------------------ response pipeline
  // Stage 1 is aligned with the array read register. Only one access is
  // granted per cycle, so a single shared pipeline carries the port tag.
  logic             s1_valid, s1_port, s1_we, s1_err;
  logic [Lanes-1:0] s1_sel;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid <= 1'b0;
      s1_port  <= 1'b0;
      s1_we    <= 1'b0;
      s1_sel   <= '0;
    end else begin
      s1_valid <= acc;
      s1_port  <= g_port;
      s1_we    <= g_we;
      s1_sel   <= g_sel;
    end
  end

  // Only the lanes the reader selected can raise ERR.
  assign s1_err = s1_valid & ~s1_we & (|(s1_sel & rd_par_bad));

  logic                 o_valid, o_port, o_we, o_err;
  logic [DataWidth-1:0] o_word;

  if (ReadLatency == 2) begin : g_lat2
    logic                 s2_valid, s2_port, s2_we, s2_err;
    logic [DataWidth-1:0] s2_word;

    // A response whose owner has dropped CYC is discarded here rather than
    // presented to a master that has already left the bus.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        s2_valid <= 1'b0;
        s2_port  <= 1'b0;
        s2_we    <= 1'b0;
        s2_err   <= 1'b0;
        s2_word  <= '0;
      end else begin
        s2_valid <= s1_valid & (s1_port ? B_CYC : A_CYC);
        s2_port  <= s1_port;
        s2_we    <= s1_we;
        s2_err   <= s1_err;
        s2_word  <= rd_word;
      end
    end

    assign o_valid = s2_valid;
    assign o_port  = s2_port;
    assign o_we    = s2_we;
    assign o_err   = s2_err;
    assign o_word  = s2_word;
  end else begin : g_lat1
    assign o_valid = s1_valid;
    assign o_port  = s1_port;
    assign o_we    = s1_we;
    assign o_err   = s1_err;
    assign o_word  = rd_word;
  end

  // ---------------------------------------------------------------- outputs
  // Read data is gated by the reset-cleared valid flag, so DAT_O drops to zero
  // as soon as RST_N falls, even though rd_word has no reset.
  assign A_ACK   = o_valid & ~o_port & ~o_err;
  assign A_ERR   = o_valid & ~o_port &  o_err;
  assign B_ACK   = o_valid &  o_port & ~o_err;
  assign B_ERR   = o_valid &  o_port &  o_err;
  assign A_DAT_O = (o_valid & ~o_port & ~o_we) ? o_word : '0;
  assign B_DAT_O = (o_valid &  o_port & ~o_we) ? o_word : '0;

endmodule
